// File: rtl/ahb_apb_pkg.sv
// ahb_apb_pkg: AHB-Lite/APB encodings and the bridge state type shared by the bridge.
package ahb_apb_pkg;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic       HRESP_OKAY    = 1'b0;
   localparam logic       HRESP_ERROR   = 1'b1;
   typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, DONE, ERR1, ERR2} state_t;
endpackage

// File: rtl/ahb2apb_bridge.sv
// ahb2apb_bridge: AHB-Lite slave to APB3 master, one stalled transfer at a time.
// Define AHB2APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait cycles.
module ahb2apb_bridge
   import ahb_apb_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] haddr,
   input  logic              hwrite,
   input  logic [2:0]        hsize,
   input  logic [1:0]        htrans,
   input  logic [31:0]       hwdata,
   input  logic              hsel,
   input  logic              hreadyin,
   output logic              hreadyout,
   output logic [31:0]       hrdata,
   output logic              hresp,
   output logic [ADDR_W-1:0] paddr,
   output logic              pwrite,
   output logic              psel,
   output logic              penable,
   output logic [31:0]       pwdata,
   input  logic [31:0]       prdata,
   input  logic              pready,
   input  logic              pslverr
);
   state_t state;
   logic   accept;
   logic   timeout;

   assign accept = (state == IDLE || state == DONE || state == ERR2) && hsel && hreadyin &&
                   (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);

`ifdef AHB2APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt;

   // Fires on the wait cycle that brings the count up to TIMEOUT_CYCLES.
   assign timeout = cnt == CNT_W'(TIMEOUT_CYCLES - 1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (state == SETUP)
         cnt <= '0;
      else if (state == ACCESS && !pready)
         cnt <= cnt + 1'b1;
   end
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         hreadyout <= 1'b1;
         hresp     <= HRESP_OKAY;
         hrdata    <= '0;
         psel      <= 1'b0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
      end else begin
         case (state)
            IDLE, DONE, ERR2:
               if (accept) begin
                  paddr     <= haddr;
                  pwrite    <= hwrite;
                  hreadyout <= 1'b0;
                  if (hsize != HSIZE_WORD) begin
                     state <= ERR1;
                     hresp <= HRESP_ERROR;
                  end else begin
                     state <= hwrite ? WDATA : SETUP;
                     psel  <= !hwrite;
                     hresp <= HRESP_OKAY;
                  end
               end else begin
                  state     <= IDLE;
                  hreadyout <= 1'b1;
                  hresp     <= HRESP_OKAY;
               end
            WDATA: begin
               pwdata <= hwdata;
               psel   <= 1'b1;
               state  <= SETUP;
            end
            SETUP: begin
               penable <= 1'b1;
               state   <= ACCESS;
            end
            ACCESS:
               // A completing pready takes priority over a coincident timeout.
               if (pready || timeout) begin
                  psel    <= 1'b0;
                  penable <= 1'b0;
                  if (pready && !pslverr) begin
                     state     <= DONE;
                     hreadyout <= 1'b1;
                     if (!pwrite)
                        hrdata <= prdata;
                  end else begin
                     state <= ERR1;
                     hresp <= HRESP_ERROR;
                  end
               end
            ERR1: begin
               state     <= ERR2;
               hreadyout <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ahb2apb_bridge.sv
// tb_ahb2apb_bridge: randomized self-checking bench for ahb2apb_bridge against a cycle-timeline model.
// Build with AHB2APB_TIMEOUT_EN defined to check the ACCESS timeout with TIMEOUT_CYCLES=4.
`timescale 1ns/1ps
module tb_ahb2apb_bridge;
   import ahb_apb_pkg::*;
`ifdef AHB2APB_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 255;
`endif
   localparam int P_WDATA = 0, P_SETUP = 1, P_ACCESS = 2, P_DONE = 3, P_ERR1 = 4, P_ERR2 = 5;
   localparam logic [31:0] LED = 32'h8000_0000;

   logic        clk = 1'b0, reset = 1'b1;
   logic [31:0] haddr, hwdata, hrdata, paddr, pwdata, prdata;
   logic        hwrite, hsel, hreadyin, hreadyout, hresp, pwrite, psel, penable, pready, pslverr;
   logic [2:0]  hsize;
   logic [1:0]  htrans;
   int          checks = 0, errors = 0;
   logic [31:0] exp_hrdata = '0;
   logic [31:0] slave_mem [logic [31:0]];
   logic [31:0] model_mem [logic [31:0]];

   ahb2apb_bridge #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .htrans(htrans),
      .hwdata(hwdata), .hsel(hsel), .hreadyin(hreadyin), .hreadyout(hreadyout), .hrdata(hrdata),
      .hresp(hresp), .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
      .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [31:0] slave_rd(input logic [31:0] a);
      return slave_mem.exists(a) ? slave_mem[a] : 32'h0;
   endfunction

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      return model_mem.exists(a) ? model_mem[a] : 32'h0;
   endfunction

   // Bus phase of the i-th cycle after the accepting edge.
   function automatic int phase_of(input int i, input bit wr, input bit serr, input int waits, input bit err);
      int j;
      j = i - int'(wr);
      if (serr) return i == 0 ? P_ERR1 : P_ERR2;
      if (wr && i == 0) return P_WDATA;
      if (j == 0) return P_SETUP;
      if (j <= waits + 1) return P_ACCESS;
      if (!err) return P_DONE;
      return j == waits + 2 ? P_ERR1 : P_ERR2;
   endfunction

   // Expected {psel, penable, hreadyout, hresp} for a phase.
   function automatic logic [3:0] vec_of(input int ph);
      return {ph == P_SETUP || ph == P_ACCESS, ph == P_ACCESS, ph == P_DONE || ph == P_ERR2,
              ph == P_ERR1 || ph == P_ERR2};
   endfunction

   // Presents one transfer at the current negedge and follows it to DONE/ERR2, ending on that cycle.
   task automatic xfer(input logic [31:0] addr, input bit wr, input logic [2:0] size,
                       input logic [31:0] wdata, input int waits, input bit err);
      bit serr;
      int len, ph, k;
      logic [3:0] exp_v;
      serr = size != HSIZE_WORD;
      len = serr ? 2 : int'(wr) + waits + 3 + int'(err);
      if (!serr && !err) begin
         if (wr) model_mem[addr] = wdata;
         else exp_hrdata = model_rd(addr);
      end
      hsel = 1'b1; hreadyin = 1'b1; haddr = addr; hwrite = wr; hsize = size;
      htrans = $urandom_range(0, 1) ? HTRANS_NONSEQ : HTRANS_SEQ;
      for (int i = 0; i < len; i++) begin
         @(posedge clk); @(negedge clk);
         ph = phase_of(i, wr, serr, waits, err);
         if (i == 0) begin
            hwdata = wdata;
            hsel = 1'($urandom_range(0, 1));
            htrans = $urandom_range(0, 1) ? HTRANS_IDLE : HTRANS_BUSY;
            haddr = $urandom; hwrite = 1'($urandom_range(0, 1)); hsize = 3'($urandom_range(0, 7));
         end else hwdata = $urandom;
         exp_v = vec_of(ph);
         checks++;
         if ({psel, penable, hreadyout, hresp} !== exp_v) begin
            errors++;
            $display("FAIL ctrl a=%h wr=%0b cyc=%0d ph=%0d: got %b want %b", addr, wr, i, ph,
                     {psel, penable, hreadyout, hresp}, exp_v);
         end
         if (ph == P_SETUP || ph == P_ACCESS) begin
            checks++;
            if (paddr !== addr || pwrite !== wr || (wr && pwdata !== wdata)) begin
               errors++;
               $display("FAIL apb_fields cyc=%0d: got paddr=%h pwrite=%b pwdata=%h want %h %b %h",
                        i, paddr, pwrite, pwdata, addr, wr, wdata);
            end
         end
         if (ph == P_ACCESS) begin
            k = i - int'(wr) - 1;
            pready = k == waits;
            pslverr = k == waits ? err : 1'($urandom_range(0, 1));
            prdata = k == waits ? slave_rd(paddr) : $urandom;
            if (k == waits && !err && pwrite) slave_mem[paddr] = pwdata;
         end else begin
            pready = 1'b0; pslverr = 1'($urandom_range(0, 1)); prdata = $urandom;
         end
         if (ph == P_DONE || ph == P_ERR2) begin
            checks++;
            if (hrdata !== exp_hrdata) begin
               errors++;
               $display("FAIL hrdata a=%h: got %h want %h", addr, hrdata, exp_hrdata);
            end
         end
      end
   endtask

   // Non-accepted bus cycles: IDLE/BUSY, deselected or not ready, all zero-wait OKAY.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         hsel = 1'($urandom_range(0, 1)); hreadyin = 1'($urandom_range(0, 1));
         htrans = 2'($urandom_range(0, 3));
         if (htrans[1] && hsel && hreadyin) htrans = $urandom_range(0, 1) ? HTRANS_IDLE : HTRANS_BUSY;
         haddr = $urandom; hwrite = 1'($urandom_range(0, 1)); hsize = 3'($urandom_range(0, 7));
         pready = 1'b0; pslverr = 1'($urandom_range(0, 1));
         @(posedge clk); @(negedge clk);
         checks++;
         if ({psel, penable, hreadyout, hresp} !== 4'b0010 || hrdata !== exp_hrdata) begin
            errors++;
            $display("FAIL idle: got ctrl=%b hrdata=%h want 0010 %h", {psel, penable, hreadyout, hresp},
                     hrdata, exp_hrdata);
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      @(negedge clk); @(negedge clk);
      checks++;
      if ({psel, penable, pwrite, hreadyout, hresp} !== 5'b00010 || hrdata !== 0 || paddr !== 0 || pwdata !== 0) begin
         errors++;
         $display("FAIL reset_values: got ctrl=%b hrdata=%h paddr=%h pwdata=%h",
                  {psel, penable, pwrite, hreadyout, hresp}, hrdata, paddr, pwdata);
      end
      reset = 1'b0;
      idle(2);
   endtask

   task automatic test_read;
      slave_mem[LED] = 32'hDEAD_BEEF;
      model_mem[LED] = 32'hDEAD_BEEF;
      xfer(LED, 1'b0, HSIZE_WORD, 32'h0, 0, 1'b0);
      idle(1);
   endtask

   task automatic test_write;
      xfer(LED, 1'b1, HSIZE_WORD, 32'h0000_00A5, 0, 1'b0);
      idle(1);
      xfer(LED, 1'b0, HSIZE_WORD, 32'h0, 0, 1'b0);
      idle(1);
   endtask

   task automatic test_wait;
      xfer(LED + 32'h4, 1'b1, HSIZE_WORD, 32'h1234_5678, 3, 1'b0);
      xfer(LED + 32'h4, 1'b0, HSIZE_WORD, 32'h0, 3, 1'b0);
      idle(1);
   endtask

   task automatic test_slverr;
      xfer(LED, 1'b0, HSIZE_WORD, 32'h0, 2, 1'b1);
      xfer(LED, 1'b1, 3'b000, 32'h0000_005A, 0, 1'b0);
      xfer(LED, 1'b1, HSIZE_WORD, 32'hFFFF_0000, 0, 1'b1);
      xfer(LED, 1'b0, HSIZE_WORD, 32'h0, 0, 1'b0);
      idle(1);
   endtask

   task automatic test_back_to_back;
      xfer(LED + 32'h8, 1'b0, HSIZE_WORD, 32'h0, 0, 1'b0);
      xfer(LED + 32'h8, 1'b1, HSIZE_WORD, 32'hCAFE_F00D, 0, 1'b0);
      xfer(LED + 32'h8, 1'b0, HSIZE_WORD, 32'h0, 1, 1'b0);
      xfer(LED + 32'hC, 1'b1, HSIZE_WORD, 32'h0BAD_0BAD, 2, 1'b0);
      idle(1);
   endtask

   task automatic test_random;
      logic [31:0] addr;
      logic [2:0]  size;
      bit wr, err;
      int waits;
      for (int n = 0; n < 60; n++) begin
         addr = LED + 32'(4 * $urandom_range(0, 3));
         wr = 1'($urandom_range(0, 1));
         size = $urandom_range(0, 5) == 0 ? 3'($urandom_range(0, 1)) : HSIZE_WORD;
         waits = $urandom_range(0, 3);
         err = $urandom_range(0, 9) == 0;
         xfer(addr, wr, size, $urandom, waits, err);
         if ($urandom_range(0, 1) == 1) idle(1 + $urandom_range(0, 1));
      end
      idle(1);
   endtask

   task automatic test_reset_mid;
      hsel = 1'b1; hreadyin = 1'b1; htrans = HTRANS_NONSEQ; haddr = LED; hwrite = 1'b0; hsize = HSIZE_WORD;
      @(posedge clk); @(negedge clk);
      htrans = HTRANS_IDLE; pready = 1'b0;
      @(posedge clk); @(negedge clk);
      checks++;
      if ({psel, penable} !== 2'b11) begin
         errors++;
         $display("FAIL reset_mid_access: got psel/penable=%b want 11", {psel, penable});
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({psel, penable, hreadyout, hresp} !== 4'b0010 || hrdata !== 0) begin
         errors++;
         $display("FAIL reset_mid_async: got ctrl=%b hrdata=%h want 0010 0", {psel, penable, hreadyout, hresp}, hrdata);
      end
      exp_hrdata = '0;
      @(negedge clk) reset = 1'b0;
      idle(2);
   endtask

   task automatic test_timeout;
      int acc;
      acc = 0;
      hsel = 1'b1; hreadyin = 1'b1; htrans = HTRANS_NONSEQ; haddr = LED; hwrite = 1'b0; hsize = HSIZE_WORD;
      @(posedge clk); @(negedge clk);
      htrans = HTRANS_IDLE; pready = 1'b0; pslverr = 1'b0;
`ifdef AHB2APB_TIMEOUT_EN
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); @(negedge clk);
         if (psel && penable) acc++;
         else break;
      end
      checks++;
      if (acc !== TO) begin
         errors++;
         $display("FAIL timeout_len: got %0d ACCESS cycles want %0d", acc, TO);
      end
      checks++;
      if ({psel, penable, hreadyout, hresp} !== 4'b0001) begin
         errors++;
         $display("FAIL timeout_err1: got %b want 0001", {psel, penable, hreadyout, hresp});
      end
      @(posedge clk); @(negedge clk);
      checks++;
      if ({psel, penable, hreadyout, hresp} !== 4'b0011) begin
         errors++;
         $display("FAIL timeout_err2: got %b want 0011", {psel, penable, hreadyout, hresp});
      end
`else
      for (int i = 0; i < 1100; i++) begin
         @(posedge clk); @(negedge clk);
         if (psel && penable && !hreadyout) acc++;
      end
      checks++;
      if (acc !== 1100) begin
         errors++;
         $display("FAIL no_timeout_hold: got %0d ACCESS cycles want 1100", acc);
      end
      pready = 1'b1; prdata = $urandom; exp_hrdata = prdata;
      @(posedge clk); @(negedge clk);
      pready = 1'b0;
      checks++;
      if ({psel, penable, hreadyout, hresp} !== 4'b0010 || hrdata !== exp_hrdata) begin
         errors++;
         $display("FAIL no_timeout_done: got ctrl=%b hrdata=%h want 0010 %h", {psel, penable, hreadyout, hresp},
                  hrdata, exp_hrdata);
      end
`endif
      idle(2);
   endtask

   initial begin
      hsel = 1'b0; htrans = HTRANS_IDLE; hreadyin = 1'b1; haddr = '0; hwrite = 1'b0; hsize = HSIZE_WORD;
      hwdata = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
      test_reset;
      test_read;
      test_write;
      test_wait;
      test_slverr;
      test_back_to_back;
      test_random;
      test_reset_mid;
      test_timeout;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ahb2apb_bridge.md
# ahb2apb_bridge

AHB-Lite slave to APB3 master bridge: accepts single AHB-Lite transfers from the Zscale system bus and issues them as APB setup/access sequences to downstream peripherals (LED register at 0x8000_0000 and future APB slaves). It is the APB initiator counterpart to the APB responders already hung off the core. Each AHB transfer is stalled via `hreadyout` until the APB slave completes. APB errors are converted into a two-cycle AHB ERROR response.

## Interface
- `ADDR_W`, 32: address width of `haddr`/`paddr`.
- `TIMEOUT_CYCLES`, 255: ACCESS cycles before abort; used only with timeout compiled in.
- `clk` in 1: clock, rising-edge.
- `reset` in 1: asynchronous, active-high.
- `haddr` in ADDR_W: AHB address.
- `hwrite` in 1: AHB write.
- `hsize` in 3: AHB size.
- `htrans` in 2: AHB transfer type.
- `hwdata` in 32: AHB write data, valid in data phase.
- `hsel` in 1: slave select.
- `hreadyin` in 1: bus ready.
- `hreadyout` out 1: bridge ready.
- `hrdata` out 32: read data.
- `hresp` out 1: 0 OKAY, 1 ERROR.
- `paddr` out ADDR_W: APB address.
- `pwrite` out 1: APB write.
- `psel` out 1: APB select.
- `penable` out 1: APB enable.
- `pwdata` out 32: APB write data.
- `prdata` in 32: APB read data.
- `pready` in 1: APB ready.
- `pslverr` in 1: APB slave error.

## Operation
- States: IDLE, WDATA, SETUP, ACCESS, DONE, ERR1, ERR2.
- Accept condition: `hsel && hreadyin && htrans[1]` (NONSEQ/SEQ) while in IDLE, DONE or ERR2. IDLE/BUSY transfers get a zero-wait OKAY with no state change.
- On accept: latch `haddr` into `paddr` and `hwrite` into `pwrite`.
  - If `hsize != 3'b010`: go to ERR1; no APB transfer.
  - Else write: go to WDATA.
  - Else read: go to SETUP.
- WDATA: capture `hwdata` into `pwdata`; go to SETUP.
- SETUP: `psel`=1, `penable`=0; go to ACCESS.
- ACCESS: `psel`=1, `penable`=1.
  - `pready`=0: hold.
  - `pready`=1, `pslverr`=0: register `prdata` into `hrdata` (reads only; writes leave `hrdata` unchanged); go to DONE.
  - `pready`=1, `pslverr`=1: go to ERR1.
- DONE: `hreadyout`=1, `hresp`=0. Accept a new transfer or return to IDLE.
- ERR1: `hreadyout`=0, `hresp`=1; go to ERR2.
- ERR2: `hreadyout`=1, `hresp`=1. Accept a new transfer or return to IDLE.
- `hreadyout` is 0 in WDATA, SETUP, ACCESS and ERR1; 1 otherwise.
- `paddr`, `pwrite` and `pwdata` stay stable from SETUP through the end of ACCESS.
- Outputs are registered or decoded from state only; there are no combinational input-to-output paths.

## Timing
- Reset values:
  - State IDLE.
  - `hreadyout`=1, `hresp`=0, `hrdata`=0.
  - `psel`=0, `penable`=0, `pwrite`=0, `paddr`=0, `pwdata`=0.
- Read accepted at cycle T: SETUP at T+1, ACCESS at T+2. With `pready`=1 at T+2, DONE at T+3 with `hrdata` valid.
- Write: one cycle more (WDATA at T+1); DONE at T+4 with zero-wait APB.
- Each APB wait cycle adds one cycle.
- Back-to-back: a transfer accepted in DONE or ERR2 starts its WDATA/SETUP in the next cycle, with no IDLE gap.
- Reset mid-transfer: `psel` and `penable` drop immediately (asynchronous); the APB transfer is abandoned.
- `pslverr` is sampled only when `pready`=1 in ACCESS and is ignored otherwise.

## Configuration
- `AHB2APB_TIMEOUT_EN` defined:
  - A counter clears on SETUP→ACCESS and increments each ACCESS cycle while `pready`=0.
  - If the count reaches `TIMEOUT_CYCLES`, drop `psel`/`penable` and go to ERR1.
  - A `pready` in the same cycle as the timeout wins.
- Undefined: no counter; ACCESS waits indefinitely.

## Structure
- Package `ahb_apb_pkg` holds:
  - `HTRANS_IDLE`, `HTRANS_BUSY`, `HTRANS_NONSEQ`, `HTRANS_SEQ`.
  - `HSIZE_WORD`.
  - `HRESP_OKAY`, `HRESP_ERROR`.
  - The bridge state enum.
- No sub-module; the timeout counter is inline and guarded by the macro.

## Test plan
- Read with `prdata`=0xDEAD_BEEF, `pready`=1 immediately:
  - `haddr`=0x8000_0000 accepted at T.
  - `psel`=1 at T+1; `penable`=1 at T+2.
  - `hrdata`=0xDEAD_BEEF with `hreadyout`=1 and OKAY at T+3.
- Write of 0x0000_00A5 to the LED register at 0x8000_0000: APB write with `pwdata`=0xA5 seen in SETUP and ACCESS; the LED register reads back 0xA5; DONE at T+4.
- `pready` held low 3 cycles during a read: ACCESS lasts 4 cycles; `paddr` stable throughout; `hreadyout` low until DONE.
- `pslverr`=1 with `pready`=1: two-cycle ERROR, with `hreadyout` 0 then 1 and `hresp`=1 both cycles. A byte write (`hsize`=0) gives an ERROR with `psel` never asserted.
- Back-to-back read then write accepted in DONE: no idle cycle between them. Asserting `reset` during ACCESS drops `psel`/`penable` immediately and restores `hreadyout`=1.
- With `AHB2APB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, `pready` tied low: ERR1 follows 4 ACCESS cycles. Without the macro, the bridge stays in ACCESS for over 1000 cycles.
